// File: rtl/mips_cpu_load_unit.sv
// MIPS load unit: issues one word read per load and aligns/extends/merges the
// returned word into a registered rt writeback value.
module mips_cpu_load_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  insop,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        addr_error
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;

    state_t      state_q, state_d;
    logic [5:0]  insop_q;
    logic [31:0] addr_q;
    logic [31:0] reg_q;
    logic        err_q;

    logic        supported;
    logic        misaligned;
    logic [31:0] load_result;
    logic [1:0]  o;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Request decode is done on the incoming operands so IDLE can skip REQ.
    always_comb begin
        supported  = (insop == OP_LB)  || (insop == OP_LH)  || (insop == OP_LWL) ||
                     (insop == OP_LW)  || (insop == OP_LBU) || (insop == OP_LHU) ||
                     (insop == OP_LWR);
        misaligned = (((insop == OP_LH) || (insop == OP_LHU)) && addr[0]) ||
                     ((insop == OP_LW) && (addr[1:0] != 2'b00));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (misaligned || !supported) ? DONE : REQ;
            REQ:  if (!mem_waitrequest) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o           = addr_q[1:0];
        sel_byte    = 8'h00;
        sel_half    = o[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        load_result = 32'h0;
        case (o)
            2'd0: sel_byte = mem_readdata[7:0];
            2'd1: sel_byte = mem_readdata[15:8];
            2'd2: sel_byte = mem_readdata[23:16];
            default: sel_byte = mem_readdata[31:24];
        endcase
        case (insop_q)
            OP_LB:  load_result = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU: load_result = {24'h0, sel_byte};
            OP_LH:  load_result = {{16{sel_half[15]}}, sel_half};
            OP_LHU: load_result = {16'h0, sel_half};
            OP_LW:  load_result = mem_readdata;
            // LWL fills the high bytes of rt from the word's low bytes.
            OP_LWL: begin
                case (o)
                    2'd0: load_result = {mem_readdata[7:0],  reg_q[23:0]};
                    2'd1: load_result = {mem_readdata[15:0], reg_q[15:0]};
                    2'd2: load_result = {mem_readdata[23:0], reg_q[7:0]};
                    default: load_result = mem_readdata;
                endcase
            end
            OP_LWR: begin
                case (o)
                    2'd0: load_result = mem_readdata;
                    2'd1: load_result = {reg_q[31:24], mem_readdata[31:8]};
                    2'd2: load_result = {reg_q[31:16], mem_readdata[31:16]};
                    default: load_result = {reg_q[31:8], mem_readdata[31:24]};
                endcase
            end
            default: load_result = 32'h0;
        endcase
    end

    // NOTE: only registers that are architecturally visible after reset are
    // required to clear, but all of these are cheap flops so all are cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insop_q <= 6'h0;
            addr_q  <= 32'h0;
            reg_q   <= 32'h0;
            err_q   <= 1'b0;
            out     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    insop_q <= insop;
                    addr_q  <= addr;
                    reg_q   <= reg_data;
                    err_q   <= misaligned;
                    if (misaligned || !supported) out <= 32'h0;
                end
                REQ: if (!mem_waitrequest) out <= load_result;
                default: ;
            endcase
        end
    end

    assign mem_read    = (state_q == REQ);
    assign mem_address = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign addr_error  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mips_cpu_load_unit.sv
// Randomized bench for mips_cpu_load_unit against a byte-arithmetic reference model.
module tb_mips_cpu_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  insop;
    logic [31:0] addr;
    logic [31:0] reg_data;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        addr_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_out  = 32'h0;

    mips_cpu_load_unit dut (
        .clk(clk), .reset(reset), .start(start), .insop(insop), .addr(addr),
        .reg_data(reg_data), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .mem_read(mem_read),
        .mem_address(mem_address), .busy(busy), .done(done), .out(out),
        .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: plain shifts, masks and two's-complement arithmetic.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, r, w,
                                  output logic [31:0] res, output bit misal, output bit unsup);
        int o;
        o     = int'(a[1:0]);
        misal = 1'b0;
        unsup = 1'b0;
        res   = 32'h0;
        case (op)
            6'b100000: begin
                res = (w >> (8 * o)) & 32'hFF;
                if (res >= 32'h80) res = res - 32'h100;
            end
            6'b100100: res = (w >> (8 * o)) & 32'hFF;
            6'b100001: begin
                misal = (o % 2) != 0;
                res   = (w >> (16 * (o / 2))) & 32'hFFFF;
                if (res >= 32'h8000) res = res - 32'h10000;
            end
            6'b100101: begin
                misal = (o % 2) != 0;
                res   = (w >> (16 * (o / 2))) & 32'hFFFF;
            end
            6'b100011: begin
                misal = (o != 0);
                res   = w;
            end
            6'b100010: res = 32'((64'(w) << (8 * (3 - o))) |
                                 (64'(r) & (64'hFFFF_FFFF >> (8 * (o + 1)))));
            6'b100110: res = (w >> (8 * o)) | (r & ~(32'hFFFF_FFFF >> (8 * o)));
            default:   unsup = 1'b1;
        endcase
        if (misal || unsup) res = 32'h0;
    endfunction

    task automatic run_load(input logic [5:0] op, input logic [31:0] a, r, w, input int waits);
        logic [31:0] res;
        bit          misal, unsup;
        model(op, a, r, w, res, misal, unsup);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        start           = 1'b1;
        insop           = op;
        addr            = a;
        reg_data        = r;
        mem_waitrequest = 1'($urandom);
        mem_readdata    = $urandom;
        @(negedge clk);
        start    = 1'b0;
        insop    = 6'($urandom);
        addr     = $urandom;
        reg_data = $urandom;
        if (misal || unsup) begin
            check("err_done", 32'(done), 32'h1);
            check("err_flag", 32'(addr_error), 32'(misal));
            check("err_mem_read", 32'(mem_read), 32'h0);
            check("err_out", out, 32'h0);
            exp_out = 32'h0;
        end else begin
            for (int i = 0; i <= waits; i++) begin
                check("req_mem_read", 32'(mem_read), 32'h1);
                check("req_mem_address", mem_address, {a[31:2], 2'b00});
                check("req_done", 32'(done), 32'h0);
                if (i < waits) begin
                    mem_waitrequest = 1'b1;
                    mem_readdata    = $urandom;
                end else begin
                    mem_waitrequest = 1'b0;
                    mem_readdata    = w;
                end
                @(negedge clk);
            end
            check("done", 32'(done), 32'h1);
            check("done_flag", 32'(addr_error), 32'h0);
            check("done_mem_read", 32'(mem_read), 32'h0);
            check("out", out, res);
            exp_out         = res;
            mem_readdata    = $urandom;
            mem_waitrequest = 1'($urandom);
        end
        @(negedge clk);
        check("post_done", 32'(done), 32'h0);
        check("post_busy", 32'(busy), 32'h0);
        check("hold_out", out, exp_out);
    endtask

    initial begin
        int n_done;
        int n_rd;
        logic [5:0] op;

        reset           = 1'b1;
        start           = 1'b0;
        insop           = 6'h0;
        addr            = 32'h0;
        reg_data        = 32'h0;
        mem_readdata    = 32'h0;
        mem_waitrequest = 1'b0;
        #1;
        check("rst_mem_read", 32'(mem_read), 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_out", out, 32'h0);
        check("rst_addr_error", 32'(addr_error), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_load(6'b100000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        check("lb_example", out, 32'hFFFF_FF80);
        run_load(6'b100101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 3);
        check("lhu_example", out, 32'h0000_BEEF);
        run_load(6'b100011, 32'h0000_3001, 32'h0, 32'h1234_5678, 0);
        check("lw_misaligned", out, 32'h0);
        run_load(6'b100010, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 0);
        check("lwl_example", out, 32'hCCDD_3344);
        run_load(6'b100110, 32'h0000_4001, 32'h1122_3344, 32'hAABB_CCDD, 1);
        check("lwr_example", out, 32'h11AA_BBCC);

        // Reset in the middle of a stalled access.
        @(negedge clk);
        start           = 1'b1;
        insop           = 6'b100101;
        addr            = 32'h0000_2002;
        mem_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_req_mem_read", 32'(mem_read), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_read", 32'(mem_read), 32'h0);
        check("arst_out", out, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_mem_address", mem_address, 32'h0);
        exp_out = 32'h0;
        @(negedge clk);
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'h0);
        end
        run_load(6'b100011, 32'h0, 32'h0, 32'hCAFE_F00D, 0);

        // start held high: one completion per IDLE acceptance (period 3 cycles).
        @(negedge clk);
        start           = 1'b1;
        insop           = 6'b100011;
        addr            = 32'h0000_0008;
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'h5A5A_0F0F;
        n_done = 0;
        n_rd   = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_done += int'(done);
            n_rd   += int'(mem_read);
        end
        start = 1'b0;
        check("held_start_dones", 32'(n_done), 32'd3);
        check("held_start_reads", 32'(n_rd), 32'd3);
        @(negedge clk);
        check("held_start_out", out, 32'h5A5A_0F0F);
        exp_out = 32'h5A5A_0F0F;

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 8) op = {3'b100, 3'($urandom)};
            else                          op = 6'($urandom);
            run_load(op, $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_load_unit.md
MIPS_CPU_LOAD_UNIT -- requirements
Module: mips_cpu_load_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request a load; sampled only in IDLE.
REQ-005 insop  input  6  load opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110.
REQ-006 addr  input  32  effective byte address.
REQ-007 reg_data  input  32  current rt value; merge source for LWL/LWR.
REQ-008 mem_readdata  input  32  data memory read word; byte lane k = bits [8k+7:8k].
REQ-009 mem_waitrequest  input  1  memory stall; read data valid in a cycle with mem_read=1 and mem_waitrequest=0.
REQ-010 mem_read  output  1  memory read strobe.
REQ-011 mem_address  output  32  word-aligned read address.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 out  output  32  registered load result for rt writeback.
REQ-015 addr_error  output  1  misaligned access flag, valid while done=1.

Function
REQ-016 FSM states: IDLE, REQ, DONE; encoding is implementer's choice.
REQ-017 IDLE with start=1: latch insop, addr, reg_data.
- Next state is DONE if misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]!=0) or insop unsupported.
- Otherwise next state is REQ.
REQ-018 REQ: mem_read=1, mem_address={addr_latched[31:2],2'b00}, both held stable.
- Remain in REQ while mem_waitrequest=1.
- On mem_waitrequest=0: register the result into out and go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE.
- addr_error=1 in DONE only for the misaligned case.
- Misaligned or unsupported requests: out=0 and mem_read never asserted.
REQ-020 Let o = addr_latched[1:0] and w = mem_readdata.
REQ-021 LB/LBU: byte w[8o+7:8o], sign-extended (LB) or zero-extended (LBU) to 32 bits.
REQ-022 LH/LHU: halfword w[16*o[1]+15:16*o[1]], sign-extended (LH) or zero-extended (LHU).
REQ-023 LW: out = w.
REQ-024 LWL: out = (w << 8*(3-o)) OR (reg_data AND (32'hFFFFFFFF >> 8*(o+1))); for o=3 the mask is zero.
REQ-025 LWR: out = (w >> 8*o) OR (reg_data AND ~(32'hFFFFFFFF >> 8*o)); for o=0 the mask is zero.
- LWL and LWR never raise addr_error.
REQ-026 out holds its value between completions; it changes only on entry to DONE.
REQ-027 start is ignored while busy=1; there is no queueing.
REQ-028 Minimum latency: start accepted at edge T, mem_read high in cycle T+1, done high in cycle T+2 if no wait; each wait cycle adds one.
REQ-029 mem_readdata is ignored whenever mem_read=0 or mem_waitrequest=1.

Reset
REQ-030 When reset is asserted, all of the following take effect asynchronously: state=IDLE, out=0, done=0, addr_error=0, mem_read=0, mem_address=0, busy=0.
REQ-031 Reset mid-REQ abandons the access: mem_read drops immediately, no done pulse is produced, and out=0.
REQ-032 First start is accepted on the first rising edge after reset deasserts.

Verification
REQ-033 LB, addr=0x1003, w=0x80FF_1234, no wait -> mem_address=0x1000, done at T+2, out=0xFFFFFF80.
REQ-034 LHU, addr=0x2002, w=0xBEEF_0000, mem_waitrequest high for 3 cycles -> mem_read high for 4 cycles, done at T+5, out=0x0000BEEF.
REQ-035 LW, addr=0x3001 -> no mem_read, done at T+1 with addr_error=1, out=0.
REQ-036 LWL, addr=0x4001, w=0xAABBCCDD, reg_data=0x11223344 -> out=0xCCDD3344; LWR with the same inputs -> out=0x11AABBCC.
REQ-037 Reset asserted during REQ with waitrequest=1 -> mem_read=0 and out=0 immediately, no done pulse; a new LW at 0x0 then completes normally.
REQ-038 start held high through a whole transaction -> exactly one done per IDLE acceptance; no start is accepted during REQ or DONE.
